aes_key_expander: RTL
=====================

# aes_key_expander

AES-128 key schedule unit that sits directly downstream of the AES main controller. The controller holds `key_en` high and drives the user key. This block latches the key and generates all 11 round keys at one round key per cycle into an internal buffer. It then raises `key_d`, which moves the controller into encryption or decryption. The encrypt/decrypt datapaths read round keys through a combinational index port.

## Interface
Parameters:
- none; AES-128 only (10 rounds, 11 round keys), fixed by `aes_pkg` constants

Ports:
- `clk`  in  1  single clock for all state
- `rst`  in  1  synchronous, active-high reset
- `key_en`  in  1  expansion request from the controller; a level, held for the whole key-expand phase
- `key`  in  128  user key; `key[127:96]` = w0, big-endian byte order within each word
- `rk_idx`  in  4  round-key read index, 0..10
- `round_key`  out  128  combinational read of `rk[rk_idx]`; returns 0 for `rk_idx` 11..15
- `key_d`  out  1  expansion complete; level, held until `key_en` drops
- `busy`  out  1  high while expansion is in progress

## Operation
- Reset (`rst`=1 at a `clk` edge) gives:
  - state IDLE
  - `key_d`=0, `busy`=0
  - all 11 buffer entries = 0
  - round counter = 0
  - rcon = 8'h01
- States:
  - IDLE: outputs low. If `key_en`=1, write `rk[0]`=`key`, set round=1, rcon=8'h01, go to EXPAND.
  - EXPAND: `busy`=1. Each cycle compute `rk[round]` from `rk[round-1]`:
    - temp = SubWord(RotWord(w3)) ^ {rcon, 24'h0}
    - w0' = w0^temp; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'
    - Write the result, increment round, update rcon = xtime(rcon), i.e. shift left and XOR 8'h1B when bit 7 was set.
    - rcon sequence: 01,02,04,08,10,20,40,80,1B,36.
    - After writing round 10, go to DONE.
  - DONE: `key_d`=1. Stay while `key_en`=1; when `key_en`=0, go to IDLE.
- `key` is sampled only in IDLE. Changes to `key` during EXPAND or DONE are ignored.
- `key_en` dropping during EXPAND: abort to IDLE on the next edge. `key_d` never asserts. Buffer contents are invalid until a full expansion completes.
- `key_en` staying high after DONE does not restart expansion. A new expansion requires `key_en` low for at least one cycle.
- The buffer is retained in IDLE, so round keys remain readable after `key_en` drops.
- `rst` asserted mid-expansion overrides everything and gives the reset values above.
- Addition is GF(2) throughout (XOR only); no carries.

## Timing
- Edge 0 (first edge with `key_en`=1 in IDLE): `rk[0]` written, state becomes EXPAND.
- Edges 1..10: `rk[1]`..`rk[10]` written, one per edge; `busy`=1 during these cycles.
- After edge 10: state DONE, `key_d`=1. Latency from `key_en` sampled to `key_d` high is 10 cycles.
- `key_d` falls on the first edge after `key_en` is sampled low.
- `round_key` is combinational from `rk_idx` and the buffer, with zero-cycle read latency. A read of the entry being written on an edge returns the old value until that edge.

## Structure
- `aes_pkg`: state enum {IDLE, EXPAND, DONE}, `NUM_ROUNDS`=10, `NUM_RK`=11, `RCON_INIT`=8'h01, and an `xtime` function. The package is shared with the cipher datapaths.
- Sub-module `aes_sbox`: 8-bit combinational forward S-box (256-entry case). The block instantiates 4 copies for SubWord. The cipher rounds reuse the same module.
- Buffer: 11×128 register array. Round counter: 4 bits.

## Test plan
- Reset then idle: hold `rst`=1 for 2 cycles, `key_en`=0 → `key_d`=0, `busy`=0, `round_key`=0 for every `rk_idx`.
- FIPS-197 key `2b7e151628aed2a6abf7158809cf4f3c`, `key_en` held → `key_d` rises exactly 10 cycles after `key_en` is sampled. Then:
  - `rk_idx`=1 → `a0fafe1788542cb123a339392a6c7605`
  - `rk_idx`=10 → `d014f9a8c9ee2589e13f0cc8b6630ca6`
  - `rk_idx`=0 → the input key
- All-zero key → `rk_idx`=1 reads `62636363626363636263636362636363`; `rk_idx`=10 reads `b4ef5bcb3e92e21123e951cf6f8f188e`.
- Drop `key_en` at cycle 5 of EXPAND → `key_d` never asserts, state returns to IDLE. Re-asserting `key_en` gives a clean full expansion with the correct keys.
- Change `key` during EXPAND, and hold `key_en` for 5 cycles past DONE → round keys match the originally latched key; `key_d` stays high the whole time and no restart occurs. `key_d` falls one edge after `key_en` goes low.
- Assert `rst` at EXPAND round 6 → next cycle `key_d`=0, `busy`=0, all `round_key` reads return 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: controller state encoding, round constants
// and the GF(2^8) doubling helper used by the key schedule and the ciphers.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int NUM_RK     = 11;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } aes_state_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    logic [7:0] r;
    r = {b[6:0], 1'b0};
    if (b[7]) begin
      r = r ^ 8'h1b;
    end else begin
      r = r ^ 8'h00;
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational; shared with the cipher rounds.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Table lookup of the forward substitution.
  always_comb begin
    out_byte = 8'h00;
    case (in_byte)
      8'h00: out_byte = 8'h63; 8'h01: out_byte = 8'h7c; 8'h02: out_byte = 8'h77; 8'h03: out_byte = 8'h7b; 8'h04: out_byte = 8'hf2; 8'h05: out_byte = 8'h6b; 8'h06: out_byte = 8'h6f; 8'h07: out_byte = 8'hc5;
      8'h08: out_byte = 8'h30; 8'h09: out_byte = 8'h01; 8'h0a: out_byte = 8'h67; 8'h0b: out_byte = 8'h2b; 8'h0c: out_byte = 8'hfe; 8'h0d: out_byte = 8'hd7; 8'h0e: out_byte = 8'hab; 8'h0f: out_byte = 8'h76;
      8'h10: out_byte = 8'hca; 8'h11: out_byte = 8'h82; 8'h12: out_byte = 8'hc9; 8'h13: out_byte = 8'h7d; 8'h14: out_byte = 8'hfa; 8'h15: out_byte = 8'h59; 8'h16: out_byte = 8'h47; 8'h17: out_byte = 8'hf0;
      8'h18: out_byte = 8'had; 8'h19: out_byte = 8'hd4; 8'h1a: out_byte = 8'ha2; 8'h1b: out_byte = 8'haf; 8'h1c: out_byte = 8'h9c; 8'h1d: out_byte = 8'ha4; 8'h1e: out_byte = 8'h72; 8'h1f: out_byte = 8'hc0;
      8'h20: out_byte = 8'hb7; 8'h21: out_byte = 8'hfd; 8'h22: out_byte = 8'h93; 8'h23: out_byte = 8'h26; 8'h24: out_byte = 8'h36; 8'h25: out_byte = 8'h3f; 8'h26: out_byte = 8'hf7; 8'h27: out_byte = 8'hcc;
      8'h28: out_byte = 8'h34; 8'h29: out_byte = 8'ha5; 8'h2a: out_byte = 8'he5; 8'h2b: out_byte = 8'hf1; 8'h2c: out_byte = 8'h71; 8'h2d: out_byte = 8'hd8; 8'h2e: out_byte = 8'h31; 8'h2f: out_byte = 8'h15;
      8'h30: out_byte = 8'h04; 8'h31: out_byte = 8'hc7; 8'h32: out_byte = 8'h23; 8'h33: out_byte = 8'hc3; 8'h34: out_byte = 8'h18; 8'h35: out_byte = 8'h96; 8'h36: out_byte = 8'h05; 8'h37: out_byte = 8'h9a;
      8'h38: out_byte = 8'h07; 8'h39: out_byte = 8'h12; 8'h3a: out_byte = 8'h80; 8'h3b: out_byte = 8'he2; 8'h3c: out_byte = 8'heb; 8'h3d: out_byte = 8'h27; 8'h3e: out_byte = 8'hb2; 8'h3f: out_byte = 8'h75;
      8'h40: out_byte = 8'h09; 8'h41: out_byte = 8'h83; 8'h42: out_byte = 8'h2c; 8'h43: out_byte = 8'h1a; 8'h44: out_byte = 8'h1b; 8'h45: out_byte = 8'h6e; 8'h46: out_byte = 8'h5a; 8'h47: out_byte = 8'ha0;
      8'h48: out_byte = 8'h52; 8'h49: out_byte = 8'h3b; 8'h4a: out_byte = 8'hd6; 8'h4b: out_byte = 8'hb3; 8'h4c: out_byte = 8'h29; 8'h4d: out_byte = 8'he3; 8'h4e: out_byte = 8'h2f; 8'h4f: out_byte = 8'h84;
      8'h50: out_byte = 8'h53; 8'h51: out_byte = 8'hd1; 8'h52: out_byte = 8'h00; 8'h53: out_byte = 8'hed; 8'h54: out_byte = 8'h20; 8'h55: out_byte = 8'hfc; 8'h56: out_byte = 8'hb1; 8'h57: out_byte = 8'h5b;
      8'h58: out_byte = 8'h6a; 8'h59: out_byte = 8'hcb; 8'h5a: out_byte = 8'hbe; 8'h5b: out_byte = 8'h39; 8'h5c: out_byte = 8'h4a; 8'h5d: out_byte = 8'h4c; 8'h5e: out_byte = 8'h58; 8'h5f: out_byte = 8'hcf;
      8'h60: out_byte = 8'hd0; 8'h61: out_byte = 8'hef; 8'h62: out_byte = 8'haa; 8'h63: out_byte = 8'hfb; 8'h64: out_byte = 8'h43; 8'h65: out_byte = 8'h4d; 8'h66: out_byte = 8'h33; 8'h67: out_byte = 8'h85;
      8'h68: out_byte = 8'h45; 8'h69: out_byte = 8'hf9; 8'h6a: out_byte = 8'h02; 8'h6b: out_byte = 8'h7f; 8'h6c: out_byte = 8'h50; 8'h6d: out_byte = 8'h3c; 8'h6e: out_byte = 8'h9f; 8'h6f: out_byte = 8'ha8;
      8'h70: out_byte = 8'h51; 8'h71: out_byte = 8'ha3; 8'h72: out_byte = 8'h40; 8'h73: out_byte = 8'h8f; 8'h74: out_byte = 8'h92; 8'h75: out_byte = 8'h9d; 8'h76: out_byte = 8'h38; 8'h77: out_byte = 8'hf5;
      8'h78: out_byte = 8'hbc; 8'h79: out_byte = 8'hb6; 8'h7a: out_byte = 8'hda; 8'h7b: out_byte = 8'h21; 8'h7c: out_byte = 8'h10; 8'h7d: out_byte = 8'hff; 8'h7e: out_byte = 8'hf3; 8'h7f: out_byte = 8'hd2;
      8'h80: out_byte = 8'hcd; 8'h81: out_byte = 8'h0c; 8'h82: out_byte = 8'h13; 8'h83: out_byte = 8'hec; 8'h84: out_byte = 8'h5f; 8'h85: out_byte = 8'h97; 8'h86: out_byte = 8'h44; 8'h87: out_byte = 8'h17;
      8'h88: out_byte = 8'hc4; 8'h89: out_byte = 8'ha7; 8'h8a: out_byte = 8'h7e; 8'h8b: out_byte = 8'h3d; 8'h8c: out_byte = 8'h64; 8'h8d: out_byte = 8'h5d; 8'h8e: out_byte = 8'h19; 8'h8f: out_byte = 8'h73;
      8'h90: out_byte = 8'h60; 8'h91: out_byte = 8'h81; 8'h92: out_byte = 8'h4f; 8'h93: out_byte = 8'hdc; 8'h94: out_byte = 8'h22; 8'h95: out_byte = 8'h2a; 8'h96: out_byte = 8'h90; 8'h97: out_byte = 8'h88;
      8'h98: out_byte = 8'h46; 8'h99: out_byte = 8'hee; 8'h9a: out_byte = 8'hb8; 8'h9b: out_byte = 8'h14; 8'h9c: out_byte = 8'hde; 8'h9d: out_byte = 8'h5e; 8'h9e: out_byte = 8'h0b; 8'h9f: out_byte = 8'hdb;
      8'ha0: out_byte = 8'he0; 8'ha1: out_byte = 8'h32; 8'ha2: out_byte = 8'h3a; 8'ha3: out_byte = 8'h0a; 8'ha4: out_byte = 8'h49; 8'ha5: out_byte = 8'h06; 8'ha6: out_byte = 8'h24; 8'ha7: out_byte = 8'h5c;
      8'ha8: out_byte = 8'hc2; 8'ha9: out_byte = 8'hd3; 8'haa: out_byte = 8'hac; 8'hab: out_byte = 8'h62; 8'hac: out_byte = 8'h91; 8'had: out_byte = 8'h95; 8'hae: out_byte = 8'he4; 8'haf: out_byte = 8'h79;
      8'hb0: out_byte = 8'he7; 8'hb1: out_byte = 8'hc8; 8'hb2: out_byte = 8'h37; 8'hb3: out_byte = 8'h6d; 8'hb4: out_byte = 8'h8d; 8'hb5: out_byte = 8'hd5; 8'hb6: out_byte = 8'h4e; 8'hb7: out_byte = 8'ha9;
      8'hb8: out_byte = 8'h6c; 8'hb9: out_byte = 8'h56; 8'hba: out_byte = 8'hf4; 8'hbb: out_byte = 8'hea; 8'hbc: out_byte = 8'h65; 8'hbd: out_byte = 8'h7a; 8'hbe: out_byte = 8'hae; 8'hbf: out_byte = 8'h08;
      8'hc0: out_byte = 8'hba; 8'hc1: out_byte = 8'h78; 8'hc2: out_byte = 8'h25; 8'hc3: out_byte = 8'h2e; 8'hc4: out_byte = 8'h1c; 8'hc5: out_byte = 8'ha6; 8'hc6: out_byte = 8'hb4; 8'hc7: out_byte = 8'hc6;
      8'hc8: out_byte = 8'he8; 8'hc9: out_byte = 8'hdd; 8'hca: out_byte = 8'h74; 8'hcb: out_byte = 8'h1f; 8'hcc: out_byte = 8'h4b; 8'hcd: out_byte = 8'hbd; 8'hce: out_byte = 8'h8b; 8'hcf: out_byte = 8'h8a;
      8'hd0: out_byte = 8'h70; 8'hd1: out_byte = 8'h3e; 8'hd2: out_byte = 8'hb5; 8'hd3: out_byte = 8'h66; 8'hd4: out_byte = 8'h48; 8'hd5: out_byte = 8'h03; 8'hd6: out_byte = 8'hf6; 8'hd7: out_byte = 8'h0e;
      8'hd8: out_byte = 8'h61; 8'hd9: out_byte = 8'h35; 8'hda: out_byte = 8'h57; 8'hdb: out_byte = 8'hb9; 8'hdc: out_byte = 8'h86; 8'hdd: out_byte = 8'hc1; 8'hde: out_byte = 8'h1d; 8'hdf: out_byte = 8'h9e;
      8'he0: out_byte = 8'he1; 8'he1: out_byte = 8'hf8; 8'he2: out_byte = 8'h98; 8'he3: out_byte = 8'h11; 8'he4: out_byte = 8'h69; 8'he5: out_byte = 8'hd9; 8'he6: out_byte = 8'h8e; 8'he7: out_byte = 8'h94;
      8'he8: out_byte = 8'h9b; 8'he9: out_byte = 8'h1e; 8'hea: out_byte = 8'h87; 8'heb: out_byte = 8'he9; 8'hec: out_byte = 8'hce; 8'hed: out_byte = 8'h55; 8'hee: out_byte = 8'h28; 8'hef: out_byte = 8'hdf;
      8'hf0: out_byte = 8'h8c; 8'hf1: out_byte = 8'ha1; 8'hf2: out_byte = 8'h89; 8'hf3: out_byte = 8'h0d; 8'hf4: out_byte = 8'hbf; 8'hf5: out_byte = 8'he6; 8'hf6: out_byte = 8'h42; 8'hf7: out_byte = 8'h68;
      8'hf8: out_byte = 8'h41; 8'hf9: out_byte = 8'h99; 8'hfa: out_byte = 8'h2d; 8'hfb: out_byte = 8'h0f; 8'hfc: out_byte = 8'hb0; 8'hfd: out_byte = 8'h54; 8'hfe: out_byte = 8'hbb; 8'hff: out_byte = 8'h16;
      default: out_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/aes_key_expander.sv
// AES-128 key schedule: latches the user key, produces one round key per
// cycle into an 11-entry buffer, then holds key_d until key_en drops.
module aes_key_expander
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         key_en,
  input  logic [127:0] key,
  input  logic [3:0]   rk_idx,
  output logic [127:0] round_key,
  output logic         key_d,
  output logic         busy
);

  aes_state_e   state_r;
  aes_state_e   state_s;
  logic [3:0]   round_r;
  logic [7:0]   rcon_r;
  logic         key_d_r;
  logic         busy_r;
  logic [127:0] rk_r [NUM_RK];

  logic [127:0] prev_rk_s;
  logic [31:0]  rot_s;
  logic [31:0]  sub_s;
  logic [31:0]  temp_s;
  logic [127:0] next_rk_s;

  // Select the previous round key; round 0 has no predecessor.
  always_comb begin
    prev_rk_s = 128'h0;
    for (int i = 1; i < NUM_RK; i++) begin
      if (round_r == 4'(i)) begin
        prev_rk_s = rk_r[i-1];
      end else begin
        prev_rk_s = prev_rk_s;
      end
    end
  end

  assign rot_s = {prev_rk_s[23:0], prev_rk_s[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .in_byte  (rot_s[8*g +: 8]),
      .out_byte (sub_s[8*g +: 8])
    );
  end

  // One AES-128 key-schedule step; each word chains off the previous one.
  always_comb begin
    next_rk_s = 128'h0;
    temp_s    = sub_s ^ {rcon_r, 24'h000000};
    next_rk_s[127:96] = prev_rk_s[127:96] ^ temp_s;
    next_rk_s[95:64]  = prev_rk_s[95:64]  ^ next_rk_s[127:96];
    next_rk_s[63:32]  = prev_rk_s[63:32]  ^ next_rk_s[95:64];
    next_rk_s[31:0]   = prev_rk_s[31:0]   ^ next_rk_s[63:32];
  end

  // Next-state logic; a dropped key_en aborts an expansion in flight.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (key_en) state_s = EXPAND;
        else        state_s = IDLE;
      end
      EXPAND: begin
        if (!key_en)                            state_s = IDLE;
        else if (round_r == 4'(NUM_ROUNDS))     state_s = DONE;
        else                                    state_s = EXPAND;
      end
      DONE: begin
        if (key_en) state_s = DONE;
        else        state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register with registered status flags decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      key_d_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      key_d_r <= (state_s == DONE);
      busy_r  <= (state_s == EXPAND);
    end
  end

  // Round-key buffer, round counter and rcon update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_RK; i++) rk_r[i] <= 128'h0;
      round_r <= 4'd0;
      rcon_r  <= RCON_INIT;
    end else begin
      case (state_r)
        IDLE: begin
          if (key_en) begin
            rk_r[0] <= key;
            round_r <= 4'd1;
            rcon_r  <= RCON_INIT;
          end
        end
        EXPAND: begin
          if (key_en) begin
            for (int i = 1; i < NUM_RK; i++) begin
              if (round_r == 4'(i)) rk_r[i] <= next_rk_s;
            end
            round_r <= round_r + 4'd1;
            rcon_r  <= xtime(rcon_r);
          end
        end
        default: begin
          round_r <= round_r;
        end
      endcase
    end
  end

  // Zero-latency read port; indices past the last round key read as zero.
  always_comb begin
    round_key = 128'h0;
    case (rk_idx)
      4'd0:    round_key = rk_r[0];
      4'd1:    round_key = rk_r[1];
      4'd2:    round_key = rk_r[2];
      4'd3:    round_key = rk_r[3];
      4'd4:    round_key = rk_r[4];
      4'd5:    round_key = rk_r[5];
      4'd6:    round_key = rk_r[6];
      4'd7:    round_key = rk_r[7];
      4'd8:    round_key = rk_r[8];
      4'd9:    round_key = rk_r[9];
      4'd10:   round_key = rk_r[10];
      default: round_key = 128'h0;
    endcase
  end

  assign key_d = key_d_r;
  assign busy  = busy_r;

endmodule
